// File: rtl/mul_div_seq.sv
// mul_div_seq: computes (a*b)/c with a one-bit-per-cycle restoring divider.
// One operation in flight; valid/ready handshake on both sides.
module mul_div_seq #(
    parameter int W = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quot,
    output logic [W-1:0]   quot_trunc,
    output logic [W-1:0]   rem,
    output logic           div_zero
);

    localparam int CW = $clog2(2 * W);
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   c_q;
    logic [W-1:0]   a_d;
    logic [W-1:0]   b_d;
    logic [W-1:0]   c_d;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_d;
    logic [2*W-1:0] qacc;
    logic [2*W-1:0] qacc_d;
    logic [2*W-1:0] q_nx;
    logic [2*W-1:0] quot_d;
    logic [W:0]     part;
    logic [W:0]     part_d;
    logic [W:0]     part_nx;
    logic [W+1:0]   shifted;
    logic [W+1:0]   diff;
    logic           fits;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_d;
    logic [W-1:0]   trunc_d;
    logic [W-1:0]   rem_d;
    logic           dz_d;
    logic           ov_d;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // out_valid is its own register: it rises one cycle after results land
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            prod       <= '0;
            part       <= '0;
            qacc       <= '0;
            cnt        <= '0;
            quot       <= '0;
            quot_trunc <= '0;
            rem        <= '0;
            div_zero   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            prod       <= prod_d;
            part       <= part_d;
            qacc       <= qacc_d;
            cnt        <= cnt_d;
            quot       <= quot_d;
            quot_trunc <= trunc_d;
            rem        <= rem_d;
            div_zero   <= dz_d;
            out_valid  <= ov_d;
        end
    end

    // part stays below c, so the sign of diff is the restore decision
    always_comb begin
        shifted = {part, prod[2*W-1]};
        diff    = shifted - {2'b00, c_q};
        fits    = ~diff[W+1];
        part_nx = fits ? diff[W:0] : shifted[W:0];
        q_nx    = {qacc[2*W-2:0], fits};
    end

    always_comb begin
        state_d = state;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        prod_d  = prod;
        part_d  = part;
        qacc_d  = qacc;
        cnt_d   = cnt;
        quot_d  = quot;
        trunc_d = quot_trunc;
        rem_d   = rem;
        dz_d    = div_zero;
        ov_d    = out_valid;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    dz_d    = 1'b0;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
                if (c_q == '0) begin
                    quot_d  = '1;
                    trunc_d = '1;
                    rem_d   = '0;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    part_d  = '0;
                    qacc_d  = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                prod_d = prod << 1;
                part_d = part_nx;
                qacc_d = q_nx;
                cnt_d  = cnt + CW'(1);
                if (cnt == LAST) begin
                    quot_d  = q_nx;
                    trunc_d = q_nx[W-1:0];
                    rem_d   = part_nx[W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid) begin
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mul_div_seq;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic [W-1:0]   c_i = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] quot;
    logic [W-1:0]   quot_trunc;
    logic [W-1:0]   rem;
    logic           div_zero;

    int total = 0;
    int bad = 0;

    mul_div_seq #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a_i),
        .b(b_i),
        .c(c_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot(quot),
        .quot_trunc(quot_trunc),
        .rem(rem),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // (a*b)/c from plain integer arithmetic
    task automatic model(input longint a, input longint b, input longint c,
                         output longint q, output longint t,
                         output longint r, output longint dz);
        longint p;
        p = a * b;
        if (c == 0) begin
            q  = (longint'(1) << (2 * W)) - 1;
            r  = 0;
            dz = 1;
        end else begin
            q  = p / c;
            r  = p % c;
            dz = 0;
        end
        t = q % (longint'(1) << W);
    endtask

    // transaction-level reference state
    int     cyc = 0;
    int     due = 0;
    bit     m_busy = 1'b0;
    bit     m_pend = 1'b0;
    bit     m_valid = 1'b0;
    bit     m_inrdy = 1'b1;
    longint e_q, e_t, e_r, e_dz;
    longint h_q = 0, h_t = 0, h_r = 0, h_dz = 0;

    always @(posedge clk) begin
        bit r_s, hi, ho;
        longint sa, sb, sc;
        r_s = rst;
        hi  = m_inrdy && in_valid;
        ho  = m_valid && out_ready;
        sa  = a_i;
        sb  = b_i;
        sc  = c_i;
        cyc++;
        if (r_s) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
            h_q = 0; h_t = 0; h_r = 0; h_dz = 0;
        end else begin
            if (ho) begin
                m_pend = 1'b0;
                m_busy = 1'b0;
            end
            if (hi) begin
                model(sa, sb, sc, e_q, e_t, e_r, e_dz);
                m_busy = 1'b1;
                m_pend = 1'b1;
                due = cyc + ((sc == 0) ? 2 : 2 * W + 2);
            end
        end
        #1;
        m_valid = m_pend && (cyc >= due);
        m_inrdy = !m_busy;
        chk("in_ready", in_ready, m_inrdy);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("quot", quot, e_q);
            chk("quot_trunc", quot_trunc, e_t);
            chk("rem", rem, e_r);
            chk("div_zero", div_zero, e_dz);
            h_q = e_q; h_t = e_t; h_r = e_r; h_dz = e_dz;
        end else if (!m_busy) begin
            chk("hold_quot", quot, h_q);
            chk("hold_trunc", quot_trunc, h_t);
            chk("hold_rem", rem, h_r);
            chk("hold_dz", div_zero, h_dz);
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input int lat,
                      input longint q, input longint t, input longint r,
                      input longint dz, input int stall);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        a_i = a; b_i = b; c_i = c;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("acc_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", k, lat);
        chk("lit_quot", quot, q);
        chk("lit_trunc", quot_trunc, t);
        chk("lit_rem", rem, r);
        chk("lit_dz", div_zero, dz);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_i = 6'd1; b_i = 6'd1; c_i = 6'd1;
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_quot", quot, q);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_valid", out_valid, 0);
        chk("handoff_ready", in_ready, 1);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        int s;
        s = $urandom_range(0, 7);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return W'($urandom);
    endfunction

    initial begin
        longint q, t, r, dz;
        model(50, 50, 50, q, t, r, dz);
        chk("pin_50_q", q, 50);
        model(63, 63, 1, q, t, r, dz);
        chk("pin_63_q", q, 3969);
        chk("pin_63_t", t, 1);
        model(10, 7, 3, q, t, r, dz);
        chk("pin_10_q", q, 23);
        chk("pin_10_r", r, 1);
        model(20, 3, 0, q, t, r, dz);
        chk("pin_z_q", q, 4095);
        chk("pin_z_t", t, 63);
        chk("pin_z_dz", dz, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_dz", div_zero, 0);

        op(50, 50, 50, 14, 50, 50, 0, 0, 0);
        op(63, 63, 1, 14, 3969, 1, 0, 0, 0);
        op(10, 7, 3, 14, 23, 23, 1, 0, 0);
        op(0, 5, 9, 14, 0, 0, 0, 0, 0);
        op(20, 3, 0, 2, 4095, 63, 0, 1, 0);
        op(4, 4, 2, 14, 8, 8, 0, 0, 0);
        op(7, 9, 5, 14, 12, 12, 3, 0, 10);

        // abort in the middle of the divide
        @(negedge clk);
        in_valid = 1'b1;
        a_i = 6'd50; b_i = 6'd50; c_i = 6'd50;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_quot", quot, 0);
        chk("abort_trunc", quot_trunc, 0);
        chk("abort_rem", rem, 0);
        chk("abort_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        op(50, 50, 50, 14, 50, 50, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 699) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            a_i = rnd_opnd();
            b_i = rnd_opnd();
            c_i = ($urandom_range(0, 7) == 0) ? '0 : rnd_opnd();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Sequential responder that computes (A*B)/C over a valid/ready handshake: 2W-bit product, 2W-bit quotient, W-bit remainder.
- Also outputs a W-bit truncated quotient, which is the quotient's low W bits.
- Used in the SGM datapath for cost and disparity normalisation.
- Replaces the combinational multiply-divide chain with a multi-cycle restoring divider, trading latency for area and timing.

Parameters:
W, 6, operand width of a, b and c; product and quotient are 2W bits.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands a/b/c valid
in_ready  out  1  block can accept operands
a  in  W  multiplicand
b  in  W  multiplier
c  in  W  divisor
out_valid  out  1  result valid, held until taken
out_ready  in  1  consumer accepts result
quot  out  2W  floor(a*b/c)
quot_trunc  out  W  quot[W-1:0] (modulo-2^W truncation)
rem  out  W  (a*b) mod c
div_zero  out  1  set when the captured c was 0

Behaviour:
- Reset, on the clk edge with rst=1:
  - state=IDLE, in_ready=1, out_valid=0.
  - quot=0, quot_trunc=0, rem=0, div_zero=0.
  - Internal product, partial remainder and bit counter cleared.
- Reset mid-operation aborts immediately. The next cycle is IDLE; no result is ever presented for the aborted operation.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register a, b, c; go to MUL.
  - in_ready deasserts the cycle after acceptance.
- MUL (1 cycle):
  - Register the full 2W-bit unsigned product a*b.
  - If c==0, go to DONE with quot=all ones, quot_trunc=all ones, rem=0, div_zero=1.
  - Otherwise clear the partial remainder, set count=0, go to DIV.
- DIV (exactly 2W cycles): restoring division, MSB first, one quotient bit per cycle.
  - Shift the partial remainder (W+1 bits) left and bring in the next product bit.
  - If partial >= c: subtract c and set the quotient bit to 1; else set it to 0.
  - After count reaches 2W-1, load quot, quot_trunc and rem; go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid=0 next cycle, go to IDLE. in_ready=1 in that same next cycle; no same-cycle restart.
  - Output registers keep their last value after handoff.
  - div_zero is cleared at the next acceptance.
- Latency:
  - c!=0: out_valid rises 2W+2 clocks after the accepting edge (14 for W=6).
  - c==0: out_valid rises 2 clocks after the accepting edge.
- Throughput: at most one operation per 2W+4 cycles with no backpressure.
- Ignored inputs:
  - in_valid is ignored outside IDLE; operands presented then are not captured.
  - out_ready is ignored outside DONE.
- Arithmetic: all unsigned.
  - quot is never truncated; quot_trunc is the plain low W bits, with no saturation.
  - rem < c is always guaranteed for c!=0.

Test Plan:
- a=50, b=50, c=50, out_ready=1 -> out_valid at accept+14; quot=50, quot_trunc=50, rem=0, div_zero=0.
- a=63, b=63, c=1 -> quot=3969, quot_trunc=1, rem=0 (truncation check).
- a=10, b=7, c=3 -> quot=23, quot_trunc=23, rem=1. Then a=0, b=5, c=9 -> quot=0, rem=0.
- a=20, b=3, c=0 -> out_valid at accept+2; quot=4095, quot_trunc=63, rem=0, div_zero=1. Next op a=4, b=4, c=2 -> quot=8, div_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> out_valid=0 next cycle, then in_ready=1.
- Assert rst during DIV cycle 5 -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0. Then a=50, b=50, c=50 -> quot=50 at accept+14.
